parking_occupancy_counter: RTL

Multi-lane parking occupancy counter. Each lane has two optical sensors (a = outer, b = inner); a per-lane direction decoder recognises complete entry (a→ab→b→none) and exit (b→ab→a→none) passages. Aborted or malformed sequences are rejected. A shared saturating counter tracks vehicles inside against a configured capacity. It sits between the debounced sensor inputs and the display/barrier controller of the parking meter design.

---
 rtl/parking_pkg.sv | 22 ++
 rtl/parking_occupancy_counter_if.sv | 30 +++
 rtl/parking_lane_decoder.sv | 94 +++++++++
 rtl/parking_occupancy_counter.sv | 103 ++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types for the parking occupancy counter: lane FSM state encoding
// and the {a,b} sensor codes seen by each lane decoder.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_A   = 3'd1,
    IN_AB  = 3'd2,
    IN_B   = 3'd3,
    OUT_B  = 3'd4,
    OUT_AB = 3'd5,
    OUT_A  = 3'd6,
    BAD    = 3'd7
  } lane_state_e;

  // Sensor codes written as {a,b}; a is the outer beam, b the inner one.
  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/parking_occupancy_counter_if.sv
// Bundle between the sensor front end (master) and the occupancy counter (slave).
// entry_pulse/exit_pulse act as valid strobes with no ready: every pulse is a
// completed passage and the consumer must take it in the cycle it is high.
interface parking_occupancy_counter_if #(
  parameter int N_LANES = 2,
  parameter int COUNT_W = 4
);
  logic [N_LANES-1:0]   a;
  logic [N_LANES-1:0]   b;
  logic                 clr;
  logic [COUNT_W-1:0]   occupancy;
  logic                 full;
  logic                 empty;
  logic [N_LANES-1:0]   entry_pulse;
  logic [N_LANES-1:0]   exit_pulse;
  logic [N_LANES-1:0]   lane_fault;
  logic                 ovf;
  logic                 unf;
  logic [3*N_LANES-1:0] lane_state;

  modport master (
    output a, b, clr,
    input  occupancy, full, empty, entry_pulse, exit_pulse, lane_fault, ovf, unf, lane_state
  );

  modport slave (
    input  a, b, clr,
    output occupancy, full, empty, entry_pulse, exit_pulse, lane_fault, ovf, unf, lane_state
  );
endinterface

// File: rtl/parking_lane_decoder.sv
// One sensor lane: optional synchroniser/debounce (PARKING_DEBOUNCE_EN) feeding
// the passage FSM that emits registered entry/exit pulses and a fault flag.
module parking_lane_decoder
  import parking_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a,
  input  logic        b,
  output logic        entry_pulse,
  output logic        exit_pulse,
  output logic        fault,
  output lane_state_e state_dbg
);

  logic [1:0] ab;

`ifdef PARKING_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync1, sync2, filt;
  logic [DEB_W-1:0] cnt [2];

  // A filter bit flips only once the synchronised input has disagreed with
  // it for DEB_CYCLES consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ab = filt;
`else
  localparam int deb_cycles_unused = DEB_CYCLES;
  assign ab = {a, b};
`endif

  lane_state_e state_q, state_d;
  logic        entry_d, exit_d;

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      IDLE:   case (ab) S_A: state_d = IN_A;   S_B: state_d = OUT_B;  S_AB: state_d = BAD;    default: ; endcase
      IN_A:   case (ab) S_AB: state_d = IN_AB; S_NONE: state_d = IDLE; S_B: state_d = BAD;    default: ; endcase
      IN_AB:  case (ab) S_B: state_d = IN_B;   S_A: state_d = IN_A;   S_NONE: state_d = BAD;  default: ; endcase
      IN_B:   case (ab) S_NONE: state_d = IDLE; S_AB: state_d = IN_AB; S_A: state_d = BAD;    default: ; endcase
      OUT_B:  case (ab) S_AB: state_d = OUT_AB; S_NONE: state_d = IDLE; S_A: state_d = BAD;   default: ; endcase
      OUT_AB: case (ab) S_A: state_d = OUT_A;  S_B: state_d = OUT_B;  S_NONE: state_d = BAD;  default: ; endcase
      OUT_A:  case (ab) S_NONE: state_d = IDLE; S_AB: state_d = OUT_AB; S_B: state_d = BAD;   default: ; endcase
      BAD:    if (ab == S_NONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Only the clean final release completes a passage; BAD never pulses.
    entry_d = (state_q == IN_B)  && (ab == S_NONE);
    exit_d  = (state_q == OUT_A) && (ab == S_NONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_pulse <= entry_d;
      exit_pulse  <= exit_d;
    end
  end

  assign fault     = (state_q == BAD);
  assign state_dbg = state_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// Multi-lane occupancy counter: per-lane passage decoders feed a shared
// saturating count with sticky overflow/underflow. Debounce via PARKING_DEBOUNCE_EN.
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int N_LANES    = 2,
  parameter int CAPACITY   = 15,
  parameter int DEB_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  parking_occupancy_counter_if.slave bus
);

  localparam int COUNT_W = $clog2(CAPACITY + 1);
  localparam int NET_W   = $clog2(N_LANES + 1) + 1;
  localparam int SUM_W   = COUNT_W + NET_W + 1;
  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);

  logic [N_LANES-1:0] entry_vec, exit_vec, fault_vec;
  lane_state_e        lane_state [N_LANES];

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    parking_lane_decoder #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .a           (bus.a[i]),
      .b           (bus.b[i]),
      .entry_pulse (entry_vec[i]),
      .exit_pulse  (exit_vec[i]),
      .fault       (fault_vec[i]),
      .state_dbg   (lane_state[i])
    );
  end

  logic [3*N_LANES-1:0] lane_state_flat;
  always_comb begin
    lane_state_flat = '0;
    for (int i = 0; i < N_LANES; i++) lane_state_flat[3*i +: 3] = lane_state[i];
  end

  logic [COUNT_W-1:0]      occ_q, occ_d;
  logic                    full_q, empty_q, ovf_q, unf_q;
  logic [NET_W-1:0]        n_entry, n_exit;
  logic signed [NET_W-1:0] net;
  logic signed [SUM_W-1:0] sum;
  logic                    over, under;

  // Entries and exits cancel before the clamp, so +1/-1 while full is a no-op.
  always_comb begin
    n_entry = '0;
    n_exit  = '0;
    for (int i = 0; i < N_LANES; i++) begin
      n_entry = n_entry + NET_W'(entry_vec[i]);
      n_exit  = n_exit + NET_W'(exit_vec[i]);
    end
    net   = $signed(n_entry) - $signed(n_exit);
    sum   = $signed({{(SUM_W-COUNT_W){1'b0}}, occ_q}) + SUM_W'(net);
    over  = 1'b0;
    under = 1'b0;
    occ_d = sum[COUNT_W-1:0];
    if (sum > CAP_S) begin
      over  = 1'b1;
      occ_d = COUNT_W'(CAPACITY);
    end else if (sum < 0) begin
      under = 1'b1;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (bus.clr) begin
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      full_q  <= (occ_d == COUNT_W'(CAPACITY));
      empty_q <= (occ_d == '0);
      ovf_q   <= ovf_q | over;
      unf_q   <= unf_q | under;
    end
  end

  assign bus.occupancy   = occ_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
  assign bus.entry_pulse = entry_vec;
  assign bus.exit_pulse  = exit_vec;
  assign bus.lane_fault  = fault_vec;
  assign bus.lane_state  = lane_state_flat;

endmodule
